cgra_cfg_sequencer: RTL and testbench



---
 rtl/cgra_cfg_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_cgra_cfg_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cgra_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// cgra_cfg_sequencer
//
// Context-memory sequencer driving one CGRA PE's configuration port. The host
// preloads up to DEPTH frames, each with a repeat count, while the block is
// idle. A start replays frames 0..N-1 in order, one per cycle. Each frame is
// emitted (repeat+1) times. The whole program is optionally replayed
// (loop_count+1) times.
//
// Optional feature macro: CGRA_CFG_LOOP_EN
//   defined   : loop_count is honoured (extra passes over the program)
//   undefined : loop_count is ignored and the program plays exactly once
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en/wr_addr/  host write into context memory (accepted only when idle)
//   wr_frame/wr_repeat
//   num_frames      program length, sampled at start (valid range 1..DEPTH)
//   loop_count      extra passes over the program, sampled at start
//   start           begin playback (level, sampled each edge while idle)
//   abort           return to idle immediately, no done pulse
//   hold            stall playback for this cycle
//   config_frame    registered frame to the PE
//   config_valid    registered frame-valid to the PE
//   busy            high while running
//   done            one-cycle pulse on normal completion or rejected start
//   cur_idx         index of the frame currently presented
// -----------------------------------------------------------------------------
module cgra_cfg_sequencer #(
  parameter int FRAME_WIDTH = 64,
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int REP_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [FRAME_WIDTH-1:0] wr_frame,
  input  logic [REP_WIDTH-1:0]   wr_repeat,
  input  logic [AW:0]            num_frames,
  input  logic [REP_WIDTH-1:0]   loop_count,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   hold,
  output logic [FRAME_WIDTH-1:0] config_frame,
  output logic                   config_valid,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          cur_idx
);

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  localparam logic [AW:0]          DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0]          ONE_N   = (AW+1)'(1);
  localparam logic [AW-1:0]        ONE_P   = AW'(1);
  localparam logic [REP_WIDTH-1:0] ONE_R   = REP_WIDTH'(1);

  // Context memory: intentionally not reset.
  logic [FRAME_WIDTH-1:0] mem_frame [DEPTH];
  logic [REP_WIDTH-1:0]   mem_rep   [DEPTH];

  state_t                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [REP_WIDTH-1:0]   rep_q, rep_d;
  logic [AW:0]            n_q, n_d;
  // Set by the final emission; the following edge retires the run so that
  // busy and done change one cycle after the last frame.
  logic                   fin_q, fin_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   vld_q, vld_d;
  logic                   done_q, done_d;
  logic [AW-1:0]          idx_q, idx_d;

  // Emission-source view: at the start edge the counters are taken as zero,
  // so the first frame goes out on the same edge that leaves IDLE.
  logic                   running;
  logic [AW-1:0]          e_ptr;
  logic [REP_WIDTH-1:0]   e_rep;
  logic [AW:0]            e_n;
  logic                   last_pass;
  logic                   num_ok;

  // Post-emission counter values
  logic [AW-1:0]          adv_ptr;
  logic [REP_WIDTH-1:0]   adv_rep;
  logic                   adv_fin;

`ifdef CGRA_CFG_LOOP_EN
  logic [REP_WIDTH-1:0]   pass_q, pass_d;
  logic [REP_WIDTH-1:0]   l_q, l_d;
  logic [REP_WIDTH-1:0]   e_pass, e_l, adv_pass;
`else
  logic                   unused_loop;
  assign unused_loop = ^loop_count;
`endif

  assign running = (state_q == S_RUN);
  assign num_ok  = (num_frames != '0) && (num_frames <= DEPTH_N);
  assign e_ptr   = running ? ptr_q : '0;
  assign e_rep   = running ? rep_q : '0;
  assign e_n     = running ? n_q   : num_frames;

`ifdef CGRA_CFG_LOOP_EN
  assign e_pass    = running ? pass_q : '0;
  assign e_l       = running ? l_q    : loop_count;
  assign last_pass = (e_pass == e_l);
`else
  assign last_pass = 1'b1;
`endif

  always_comb begin
    adv_ptr = e_ptr;
    adv_rep = e_rep;
    adv_fin = 1'b0;
`ifdef CGRA_CFG_LOOP_EN
    adv_pass = e_pass;
`endif
    if (e_rep < mem_rep[e_ptr]) begin
      adv_rep = e_rep + ONE_R;
    end else begin
      adv_rep = '0;
      if ({1'b0, e_ptr} == (e_n - ONE_N)) begin
        adv_ptr = '0;
        if (last_pass) begin
          adv_fin = 1'b1;
        end
`ifdef CGRA_CFG_LOOP_EN
        else begin
          adv_pass = e_pass + ONE_R;
        end
`endif
      end else begin
        adv_ptr = e_ptr + ONE_P;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rep_d   = rep_q;
    n_d     = n_q;
    fin_d   = fin_q;
    frame_d = frame_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    idx_d   = idx_q;
`ifdef CGRA_CFG_LOOP_EN
    pass_d  = pass_q;
    l_d     = l_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      fin_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_ok) begin
              state_d = S_RUN;
              n_d     = num_frames;
              frame_d = mem_frame[e_ptr];
              vld_d   = 1'b1;
              idx_d   = e_ptr;
              ptr_d   = adv_ptr;
              rep_d   = adv_rep;
              fin_d   = adv_fin;
`ifdef CGRA_CFG_LOOP_EN
              l_d     = loop_count;
              pass_d  = adv_pass;
`endif
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (fin_q) begin
            state_d = S_IDLE;
            fin_d   = 1'b0;
            done_d  = 1'b1;
          end else if (!hold) begin
            frame_d = mem_frame[e_ptr];
            vld_d   = 1'b1;
            idx_d   = e_ptr;
            ptr_d   = adv_ptr;
            rep_d   = adv_rep;
            fin_d   = adv_fin;
`ifdef CGRA_CFG_LOOP_EN
            pass_d  = adv_pass;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rep_q   <= '0;
      n_q     <= '0;
      fin_q   <= 1'b0;
      frame_q <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
`ifdef CGRA_CFG_LOOP_EN
      pass_q  <= '0;
      l_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rep_q   <= rep_d;
      n_q     <= n_d;
      fin_q   <= fin_d;
      frame_q <= frame_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
`ifdef CGRA_CFG_LOOP_EN
      pass_q  <= pass_d;
      l_q     <= l_d;
`endif
    end
  end

  // Host writes land only while idle; writes during playback are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !running && ({1'b0, wr_addr} < DEPTH_N)) begin
      mem_frame[wr_addr] <= wr_frame;
      mem_rep[wr_addr]   <= wr_repeat;
    end
  end

  assign config_frame = frame_q;
  assign config_valid = vld_q;
  assign busy         = running;
  assign done         = done_q;
  assign cur_idx      = idx_q;

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
module tb_cgra_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [63:0] wr_frame = '0;
  logic [7:0]  wr_repeat = '0;
  logic [4:0]  num_frames = '0;
  logic [7:0]  loop_count = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        hold = 1'b0;
  logic [63:0] config_frame;
  logic        config_valid;
  logic        busy;
  logic        done;
  logic [3:0]  cur_idx;

  cgra_cfg_sequencer #(
    .FRAME_WIDTH(64), .DEPTH(16), .REP_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_frame(wr_frame), .wr_repeat(wr_repeat), .num_frames(num_frames),
    .loop_count(loop_count), .start(start), .abort(abort), .hold(hold),
    .config_frame(config_frame), .config_valid(config_valid), .busy(busy),
    .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] FA = 64'hAAAA_0000_1111_0001;
  localparam logic [63:0] FB = 64'hBBBB_0000_2222_0002;
  localparam logic [63:0] FC = 64'hCCCC_0000_3333_0003;
  localparam logic [63:0] FD = 64'hDDDD_0000_4444_0004;

  typedef struct {
    logic we; logic [3:0] wa; logic [63:0] wf; logic [7:0] wrp;
    logic [4:0] nf; logic [7:0] lc; logic st; logic ab; logic hd;
    logic ev; logic [63:0] ef; logic eb; logic ed; logic [3:0] ei;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [63:0] ef,
                         input logic eb, input logic ed, input logic [3:0] ei);
    chk({tag, " config_valid"}, {63'b0, config_valid}, {63'b0, ev});
    chk({tag, " config_frame"}, config_frame, ef);
    chk({tag, " busy"}, {63'b0, busy}, {63'b0, eb});
    chk({tag, " done"}, {63'b0, done}, {63'b0, ed});
    chk({tag, " cur_idx"}, {60'b0, cur_idx}, {60'b0, ei});
  endtask

  task automatic add(input logic we, input logic [3:0] wa, input logic [63:0] wf,
                     input logic [7:0] wrp, input logic [4:0] nf, input logic [7:0] lc,
                     input logic st, input logic ab, input logic hd,
                     input logic ev, input logic [63:0] ef, input logic eb,
                     input logic ed, input logic [3:0] ei);
    vec_t v;
    v = '{we, wa, wf, wrp, nf, lc, st, ab, hd, ev, ef, eb, ed, ei};
    vecs.push_back(v);
  endtask

  // Idle write row
  task automatic wrow(input logic [3:0] wa, input logic [63:0] wf, input logic [7:0] wrp,
                      input logic [63:0] ef, input logic [3:0] ei);
    add(1'b1, wa, wf, wrp, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, ef, 1'b0, 1'b0, ei);
  endtask

  // Control row: num_frames, loop_count, start, abort, hold, then expectations
  task automatic crow(input logic [4:0] nf, input logic [7:0] lc, input logic st,
                      input logic ab, input logic hd, input logic ev, input logic [63:0] ef,
                      input logic eb, input logic ed, input logic [3:0] ei);
    add(1'b0, 4'd0, 64'd0, 8'd0, nf, lc, st, ab, hd, ev, ef, eb, ed, ei);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wr_en = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    num_frames = '0; loop_count = '0;
  endtask

  initial begin
    // Basic program: A (rep 0), B (rep 2), C (rep 0)
    wrow(4'd0, FA, 8'd0, 64'd0, 4'd0);
    wrow(4'd1, FB, 8'd2, 64'd0, 4'd0);
    wrow(4'd2, FC, 8'd0, 64'd0, 4'd0);
    crow(5'd3, 8'd0, 1, 0, 0,  1, FA, 1, 0, 4'd0);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FC, 1, 0, 4'd2);
    crow(5'd0, 8'd0, 0, 0, 0,  0, FC, 0, 1, 4'd2);
    // Restart in the cycle done is visible; hold for two cycles in the B run
    crow(5'd3, 8'd0, 1, 0, 0,  1, FA, 1, 0, 4'd0);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 1,  0, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 1,  0, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FC, 1, 0, 4'd2);
    crow(5'd0, 8'd0, 0, 0, 0,  0, FC, 0, 1, 4'd2);
    // Rewrite B with repeat 0, then start the very next cycle with loop_count=2
    wrow(4'd1, FB, 8'd0, FC, 4'd2);
    crow(5'd2, 8'd2, 1, 0, 0,  1, FA, 1, 0, 4'd0);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
`ifdef CGRA_CFG_LOOP_EN
    for (int p = 0; p < 2; p++) begin
      crow(5'd0, 8'd0, 0, 0, 0,  1, FA, 1, 0, 4'd0);
      crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    end
`endif
    crow(5'd0, 8'd0, 0, 0, 0,  0, FB, 0, 1, 4'd1);
    // Out-of-range program lengths
    crow(5'd0,  8'd0, 1, 0, 0,  0, FB, 0, 1, 4'd1);
    crow(5'd0,  8'd0, 0, 0, 0,  0, FB, 0, 0, 4'd1);
    crow(5'd17, 8'd0, 1, 0, 0,  0, FB, 0, 1, 4'd1);
    crow(5'd0,  8'd0, 0, 0, 0,  0, FB, 0, 0, 4'd1);
    // Abort has priority over start
    crow(5'd2, 8'd0, 1, 1, 0,  0, FB, 0, 0, 4'd1);
    // Abort mid-run; the write issued while running must be dropped
    crow(5'd3, 8'd0, 1, 0, 0,  1, FA, 1, 0, 4'd0);
    add(1'b1, 4'd0, FD, 8'd0, 5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 1, 0,  0, FB, 0, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  0, FB, 0, 0, 4'd1);
    // Replay shows mem[0] still holds A
    crow(5'd3, 8'd0, 1, 0, 0,  1, FA, 1, 0, 4'd0);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FB, 1, 0, 4'd1);
    crow(5'd0, 8'd0, 0, 0, 0,  1, FC, 1, 0, 4'd2);
    crow(5'd0, 8'd0, 0, 0, 0,  0, FC, 0, 1, 4'd2);
    crow(5'd0, 8'd0, 0, 0, 0,  0, FC, 0, 0, 4'd2);

    // Reset state
    #12;
    chk_all("reset", 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven section
    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_frame = vecs[i].wf;
      wr_repeat = vecs[i].wrp; num_frames = vecs[i].nf; loop_count = vecs[i].lc;
      start = vecs[i].st; abort = vecs[i].ab; hold = vecs[i].hd;
      tick();
      chk_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].ef, vecs[i].eb,
              vecs[i].ed, vecs[i].ei);
    end
    idle_inputs();

    // Asynchronous reset in the middle of a run
    num_frames = 5'd3; start = 1'b1;
    tick();
    idle_inputs();
    chk_all("rst_run0", 1'b1, FA, 1'b1, 1'b0, 4'd0);
    tick();
    chk_all("rst_run1", 1'b1, FB, 1'b1, 1'b0, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    num_frames = 5'd3; start = 1'b1;
    tick();
    idle_inputs();
    chk_all("after_rst0", 1'b1, FA, 1'b1, 1'b0, 4'd0);
    tick();
    chk_all("after_rst1", 1'b1, FB, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("after_rst2", 1'b1, FC, 1'b1, 1'b0, 4'd2);
    tick();
    chk_all("after_rst_done", 1'b0, FC, 1'b0, 1'b1, 4'd2);
    tick();
    chk_all("after_rst_idle", 1'b0, FC, 1'b0, 1'b0, 4'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
